spi_host_master: RTL and testbench
==================================

Name: spi_host_master

Overview:
- Host-side SPI master that originates the 16-bit command frames consumed by the GPIO expander's SPI-to-APB bridge. It is the initiator end of that link.
- Accepts one register read or write request per handshake, serialises it MSB-first on mosi using SPI mode 0, and captures miso in the same frame.
- Returns the captured read byte on a one-cycle response strobe.
- Sits between the host/system logic and the expander's SPI pins.

Parameters:
- BANK_NUM, 2: width of the bank-select field (frame bits 14:13).
- PADDR_WIDTH, 3: register address field width (frame bits 12:10).
- PDATA_WIDTH, 8: data field width (frame bits 7:0).
- DATA_WIDTH, 16: frame length. Must equal 1+BANK_NUM+PADDR_WIDTH+2+PDATA_WIDTH.
- CLK_DIV, 1: clk cycles per sclk half-period, >=1.
- SS_SETUP, 1: clk cycles from ss falling to the first sclk rise, >=1.
- SS_HOLD, 2: clk cycles from the last sclk fall to ss rising, >=1.
- SS_IDLE, 2: minimum clk cycles ss stays high between frames, >=1.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_write  in  1  1 = write, 0 = read (frame bit 15)
- req_sel  in  BANK_NUM  bank select
- req_addr  in  PADDR_WIDTH  register address
- req_wdata  in  PDATA_WIDTH  write data; ignored for reads
- rsp_valid  out  1  one-cycle pulse at end of frame
- rsp_rdata  out  PDATA_WIDTH  miso bits captured during frame bits 7:0
- rsp_frame  out  DATA_WIDTH  full captured miso word
- busy  out  1  high from acceptance through the end of GAP
- sclk  out  1  SPI clock, idles low
- ss  out  1  active-low slave select
- mosi  out  1  serial data out
- miso  in  1  serial data in

Behaviour:
- Reset values (asynchronous, immediate): ss=1, sclk=0, mosi=0, req_ready=0 while resetn low, rsp_valid=0, rsp_rdata=0, rsp_frame=0, busy=0, state=IDLE.
- After reset release, req_ready=1 from the first clk edge.
- Frame format: {req_write, req_sel, req_addr, 2'b00, req_wdata or 0 for reads}. Bits 9:8 are always 0.
- States:
  - IDLE: req_ready=1. On a handshake, latch the frame into tx_shift, clear rx_shift, set ss<=0, set mosi<=frame[15], set busy<=1, go to SETUP. req_ready drops in the same edge.
  - SETUP: hold sclk=0 for SS_SETUP cycles, then go to XFER.
  - XFER: a half-period counter runs in CLK_DIV cycles.
    - End of a low half: sclk<=1 and rx_shift<={rx_shift[14:0], miso}, sampled at the clk edge that raises sclk.
    - End of a high half: sclk<=0, tx_shift shifts left, mosi<=next bit, bit_cnt++.
    - After the 16th falling sclk edge, go to HOLD. mosi keeps the last bit.
  - HOLD: SS_HOLD cycles with ss=0 and sclk=0. On exit: ss<=1, rsp_valid<=1 for exactly one cycle, rsp_frame<=rx_shift, rsp_rdata<=rx_shift[7:0], mosi<=0. Go to GAP.
  - GAP: ss=1 for SS_IDLE cycles, then go to IDLE with busy<=0.
- Frame time: acceptance-to-rsp_valid = 1 + SS_SETUP + 32*CLK_DIV + SS_HOLD clk cycles. With defaults this is 36.
- Exactly 16 sclk rising edges per frame. Never a partial frame.
- rsp_valid also pulses for writes; rsp_rdata is then whatever miso returned. Consumers ignore it.
- req_valid outside IDLE has no effect. Request inputs are sampled only at the handshake, so they may change afterwards.
- rsp_rdata and rsp_frame hold their values until the next frame completes.
- Reset mid-frame: ss and sclk return to idle immediately, no rsp_valid is issued, and no partial data is exposed.
- sclk, ss and mosi are driven directly from flops. No combinational path from any input to them.

Decomposition:
- Shared package spi_frame_pkg holds:
  - frame bit positions: CMD_BIT=15, SEL_MSB/LSB=14/13, ADDR_MSB/LSB=12/10, RSVD 9:8, DATA_MSB/LSB=7/0
  - CMD_WRITE=1, CMD_READ=0
  - FSM state encoding: IDLE, SETUP, XFER, HOLD, GAP
- One sub-module, spi_sclk_div: the half-period counter producing rise_tick and fall_tick strobes; it is enabled in XFER only.
- The FSM, shift registers and bit counter stay in spi_host_master.

Test Plan:
1. Hold resetn low, then release -> ss=1, sclk=0, mosi=0, rsp_valid=0 during reset; req_ready=1 one cycle after release.
2. Write sel=2'b01, addr=3'b000, wdata=8'hFF -> mosi bits sampled on the 16 sclk rises equal 16'hA0FF; ss low for 1+32+2 cycles; rsp_valid pulses once, 36 cycles after acceptance.
3. Read sel=2'b01, addr=3'b101, miso model returns 16'h005A -> mosi carries 16'h3400; rsp_rdata=8'h5A and rsp_frame=16'h005A at the rsp_valid pulse.
4. req_valid held high with two queued requests -> second handshake occurs only after GAP; ss high for at least SS_IDLE=2 cycles between frames; busy stays high through both frames except in IDLE.
5. CLK_DIV=3 -> each sclk half lasts exactly 3 clk cycles; acceptance-to-rsp_valid = 1+1+96+2 = 100 cycles.
6. Assert resetn low after the 5th sclk rise -> ss=1 and sclk=0 within the same cycle, no rsp_valid; a following write of 16'hA0FF completes correctly.

Source files
------------

// File: rtl/spi_frame_pkg.sv
// rtl/spi_frame_pkg.sv - frame field positions, command codes and FSM states shared by the SPI host master.
package spi_frame_pkg;

   localparam int CMD_BIT  = 15;
   localparam int SEL_MSB  = 14;
   localparam int SEL_LSB  = 13;
   localparam int ADDR_MSB = 12;
   localparam int ADDR_LSB = 10;
   localparam int RSVD_MSB = 9;
   localparam int RSVD_LSB = 8;
   localparam int DATA_MSB = 7;
   localparam int DATA_LSB = 0;

   localparam logic CMD_WRITE = 1'b1;
   localparam logic CMD_READ  = 1'b0;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      XFER  = 3'd2,
      HOLD  = 3'd3,
      GAP   = 3'd4
   } spi_state_e;

endpackage

// File: rtl/spi_sclk_div.sv
// rtl/spi_sclk_div.sv - sclk half-period counter; strobes mark the end of a low half (rise) or high half (fall).
module spi_sclk_div #(
   parameter int CLK_DIV = 1
) (
   input  logic clk,
   input  logic resetn,
   input  logic en,
   output logic rise_tick,
   output logic fall_tick
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          high_q, high_d;
   logic          wrap;

   always_comb begin
      wrap   = (cnt_q == CW'(CLK_DIV - 1));
      cnt_d  = cnt_q;
      high_d = high_q;
      // Disabled outside XFER so every frame starts with a full low half.
      if (!en) begin
         cnt_d  = '0;
         high_d = 1'b0;
      end else if (wrap) begin
         cnt_d  = '0;
         high_d = ~high_q;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
      rise_tick = en && wrap && !high_q;
      fall_tick = en && wrap && high_q;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q  <= '0;
         high_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         high_q <= high_d;
      end
   end

endmodule

// File: rtl/spi_host_master.sv
// rtl/spi_host_master.sv - SPI mode-0 host master issuing 16-bit register frames and returning captured miso.
module spi_host_master
   import spi_frame_pkg::*;
#(
   parameter int BANK_NUM    = 2,
   parameter int PADDR_WIDTH = 3,
   parameter int PDATA_WIDTH = 8,
   parameter int DATA_WIDTH  = 16,
   parameter int CLK_DIV     = 1,
   parameter int SS_SETUP    = 1,
   parameter int SS_HOLD     = 2,
   parameter int SS_IDLE     = 2
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_write,
   input  logic [BANK_NUM-1:0]    req_sel,
   input  logic [PADDR_WIDTH-1:0] req_addr,
   input  logic [PDATA_WIDTH-1:0] req_wdata,
   output logic                   rsp_valid,
   output logic [PDATA_WIDTH-1:0] rsp_rdata,
   output logic [DATA_WIDTH-1:0]  rsp_frame,
   output logic                   busy,
   output logic                   sclk,
   output logic                   ss,
   output logic                   mosi,
   input  logic                   miso
);

   localparam int BW = $clog2(DATA_WIDTH + 1);
   localparam int TW = 8;

   spi_state_e             state_q, state_d;
   logic [DATA_WIDTH-1:0]  tx_q, tx_d, rx_q, rx_d;
   logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
   logic [TW-1:0]          tcnt_q, tcnt_d;
   logic                   ss_q, ss_d, sclk_q, sclk_d, mosi_q, mosi_d;
   logic                   req_ready_q, req_ready_d, busy_q, busy_d;
   logic                   rsp_valid_q, rsp_valid_d;
   logic [PDATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [DATA_WIDTH-1:0]  rsp_frame_q, rsp_frame_d;
   logic [PDATA_WIDTH-1:0] wdata_eff;
   logic [DATA_WIDTH-1:0]  frame;
   logic                   div_en, rise_tick, fall_tick;

   assign div_en = (state_q == XFER);

   spi_sclk_div #(.CLK_DIV(CLK_DIV)) u_div (
      .clk       (clk),
      .resetn    (resetn),
      .en        (div_en),
      .rise_tick (rise_tick),
      .fall_tick (fall_tick)
   );

   always_comb begin
      wdata_eff   = (req_write == CMD_WRITE) ? req_wdata : '0;
      frame       = {req_write, req_sel, req_addr, 2'b00, wdata_eff};
      state_d     = state_q;
      tx_d        = tx_q;
      rx_d        = rx_q;
      bit_cnt_d   = bit_cnt_q;
      tcnt_d      = tcnt_q;
      ss_d        = ss_q;
      sclk_d      = sclk_q;
      mosi_d      = mosi_q;
      req_ready_d = req_ready_q;
      busy_d      = busy_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_frame_d = rsp_frame_q;
      case (state_q)
         IDLE: begin
            req_ready_d = 1'b1;
            if (req_valid && req_ready_q) begin
               tx_d        = frame;
               rx_d        = '0;
               bit_cnt_d   = '0;
               tcnt_d      = '0;
               ss_d        = 1'b0;
               mosi_d      = frame[DATA_WIDTH-1];
               busy_d      = 1'b1;
               req_ready_d = 1'b0;
               state_d     = SETUP;
            end
         end
         SETUP: begin
            if (tcnt_q == TW'(SS_SETUP - 1)) begin
               tcnt_d  = '0;
               state_d = XFER;
            end else begin
               tcnt_d = tcnt_q + TW'(1);
            end
         end
         XFER: begin
            if (rise_tick) begin
               sclk_d = 1'b1;
               rx_d   = {rx_q[DATA_WIDTH-2:0], miso};
            end else if (fall_tick) begin
               sclk_d = 1'b0;
               // The final falling edge leaves mosi on the last data bit.
               if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
                  bit_cnt_d = '0;
                  tcnt_d    = '0;
                  state_d   = HOLD;
               end else begin
                  tx_d      = {tx_q[DATA_WIDTH-2:0], 1'b0};
                  mosi_d    = tx_q[DATA_WIDTH-2];
                  bit_cnt_d = bit_cnt_q + BW'(1);
               end
            end
         end
         HOLD: begin
            if (tcnt_q == TW'(SS_HOLD - 1)) begin
               ss_d        = 1'b1;
               mosi_d      = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_frame_d = rx_q;
               rsp_rdata_d = rx_q[PDATA_WIDTH-1:0];
               tcnt_d      = '0;
               state_d     = GAP;
            end else begin
               tcnt_d = tcnt_q + TW'(1);
            end
         end
         GAP: begin
            if (tcnt_q == TW'(SS_IDLE - 1)) begin
               tcnt_d      = '0;
               busy_d      = 1'b0;
               req_ready_d = 1'b1;
               state_d     = IDLE;
            end else begin
               tcnt_d = tcnt_q + TW'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         tx_q        <= '0;
         rx_q        <= '0;
         bit_cnt_q   <= '0;
         tcnt_q      <= '0;
         ss_q        <= 1'b1;
         sclk_q      <= 1'b0;
         mosi_q      <= 1'b0;
         req_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_frame_q <= '0;
      end else begin
         state_q     <= state_d;
         tx_q        <= tx_d;
         rx_q        <= rx_d;
         bit_cnt_q   <= bit_cnt_d;
         tcnt_q      <= tcnt_d;
         ss_q        <= ss_d;
         sclk_q      <= sclk_d;
         mosi_q      <= mosi_d;
         req_ready_q <= req_ready_d;
         busy_q      <= busy_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_frame_q <= rsp_frame_d;
      end
   end

   assign req_ready = req_ready_q;
   assign busy      = busy_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_frame = rsp_frame_q;
   assign sclk      = sclk_q;
   assign ss        = ss_q;
   assign mosi      = mosi_q;

endmodule

// File: tb/tb_spi_host_master.sv
// tb/tb_spi_host_master.sv - bench for spi_host_master with an SPI slave model and frame-level reference.
module tb_spi_host_master;

   logic       clk = 1'b0;
   logic       resetn;
   logic       rv;
   logic       req_write;
   logic [1:0] req_sel;
   logic [2:0] req_addr;
   logic [7:0] req_wdata;
   logic       miso = 1'b0;
   logic       dsel;

   logic        req_ready0, rsp_valid0, busy0, sclk0, ss0, mosi0;
   logic [7:0]  rsp_rdata0;
   logic [15:0] rsp_frame0;
   logic        req_ready1, rsp_valid1, busy1, sclk1, ss1, mosi1;
   logic [7:0]  rsp_rdata1;
   logic [15:0] rsp_frame1;

   logic        cur_ready, cur_rsp_valid, cur_busy, cur_sclk, cur_ss, cur_mosi;
   logic [7:0]  cur_rdata;
   logic [15:0] cur_frame;

   logic [15:0] slv_word = 16'h0000;
   logic [15:0] cap_word = 16'h0000;
   int          nrise = 0;
   logic        ss_prev = 1'b1;
   logic        sclk_prev = 1'b0;

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   spi_host_master dut0 (
      .clk(clk), .resetn(resetn), .req_valid(rv && !dsel), .req_ready(req_ready0),
      .req_write(req_write), .req_sel(req_sel), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_frame(rsp_frame0), .busy(busy0),
      .sclk(sclk0), .ss(ss0), .mosi(mosi0), .miso(miso)
   );

   spi_host_master #(.CLK_DIV(3)) dut3 (
      .clk(clk), .resetn(resetn), .req_valid(rv && dsel), .req_ready(req_ready1),
      .req_write(req_write), .req_sel(req_sel), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .rsp_frame(rsp_frame1), .busy(busy1),
      .sclk(sclk1), .ss(ss1), .mosi(mosi1), .miso(miso)
   );

   assign cur_ready     = dsel ? req_ready1 : req_ready0;
   assign cur_rsp_valid = dsel ? rsp_valid1 : rsp_valid0;
   assign cur_busy      = dsel ? busy1 : busy0;
   assign cur_sclk      = dsel ? sclk1 : sclk0;
   assign cur_ss        = dsel ? ss1 : ss0;
   assign cur_mosi      = dsel ? mosi1 : mosi0;
   assign cur_rdata     = dsel ? rsp_rdata1 : rsp_rdata0;
   assign cur_frame     = dsel ? rsp_frame1 : rsp_frame0;

   // Mode-0 slave: presents slv_word MSB first, captures mosi on each sclk rise.
   always @(cur_ss or cur_sclk) begin
      if (ss_prev && !cur_ss) begin
         cap_word = 16'h0000;
         nrise    = 0;
         miso     = slv_word[15];
      end else if (!cur_ss && cur_sclk && !sclk_prev) begin
         cap_word = {cap_word[14:0], cur_mosi};
         nrise++;
      end else if (!cur_ss && !cur_sclk && sclk_prev && nrise < 16) begin
         miso = slv_word[15 - nrise];
      end
      ss_prev   = cur_ss;
      sclk_prev = cur_sclk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] ref_frame(input logic wr, input logic [1:0] sel,
                                             input logic [2:0] addr, input logic [7:0] wd);
      return {wr, sel, addr, 2'b00, (wr ? wd : 8'h00)};
   endfunction

   task automatic wait_ready(input string tag);
      int k = 0;
      while (!cur_ready && k < 200) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_ready"}, 32'(cur_ready), 32'd1);
   endtask

   task automatic run_frame(input string tag, input logic wr, input logic [1:0] sel,
                            input logic [2:0] addr, input logic [7:0] wd, input logic [15:0] slv);
      int div, n, ssl, busy_low, run, hmin, hmax, pulses;
      div = dsel ? 3 : 1;
      slv_word  = slv;
      req_write = wr;
      req_sel   = sel;
      req_addr  = addr;
      req_wdata = wd;
      rv        = 1'b1;
      wait_ready(tag);
      @(negedge clk);
      rv        = 1'b0;
      req_write = 1'($urandom);
      req_sel   = 2'($urandom);
      req_addr  = 3'($urandom);
      req_wdata = 8'($urandom);
      n = 1; ssl = cur_ss ? 0 : 1; busy_low = cur_busy ? 0 : 1;
      run = 0; hmin = 1000; hmax = 0;
      while (!cur_rsp_valid && n < 400) begin
         @(negedge clk);
         n++;
         if (!cur_ss) ssl++;
         if (!cur_busy) busy_low++;
         if (cur_sclk) run++;
         else if (run > 0) begin
            if (run < hmin) hmin = run;
            if (run > hmax) hmax = run;
            run = 0;
         end
      end
      check({tag, "_latency"}, 32'(n), 32'(1 + 1 + 32 * div + 2));
      check({tag, "_ss_low"}, 32'(ssl), 32'(1 + 32 * div + 2));
      check({tag, "_rises"}, 32'(nrise), 32'd16);
      check({tag, "_mosi"}, 32'(cap_word), 32'(ref_frame(wr, sel, addr, wd)));
      check({tag, "_rdata"}, 32'(cur_rdata), 32'(slv[7:0]));
      check({tag, "_frame"}, 32'(cur_frame), 32'(slv));
      check({tag, "_hmin"}, 32'(hmin), 32'(div));
      check({tag, "_hmax"}, 32'(hmax), 32'(div));
      check({tag, "_busy_in_frame"}, 32'(busy_low), 32'd0);
      pulses = 1;
      repeat (4) begin
         @(negedge clk);
         if (cur_rsp_valid) pulses++;
      end
      check({tag, "_pulses"}, 32'(pulses), 32'd1);
      check({tag, "_frame_hold"}, 32'(cur_frame), 32'(slv));
      check({tag, "_busy_after"}, 32'(cur_busy), 32'd0);
      check({tag, "_ss_after"}, 32'(cur_ss), 32'd1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] slv_a, slv_b, slv_c;
      int n, gap, bl, pulses;
      resetn = 1'b0; rv = 1'b0; dsel = 1'b0;
      req_write = 1'b0; req_sel = 2'b00; req_addr = 3'b000; req_wdata = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_ss", 32'(ss0), 32'd1);
      check("rst_sclk", 32'(sclk0), 32'd0);
      check("rst_mosi", 32'(mosi0), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid0), 32'd0);
      check("rst_ready", 32'(req_ready0), 32'd0);
      check("rst_busy", 32'(busy0), 32'd0);
      check("rst_frame", 32'(rsp_frame0), 32'd0);
      check("rst_ss_div3", 32'(ss1), 32'd1);
      resetn = 1'b1;
      @(negedge clk);
      check("ready_after_rst", 32'(req_ready0), 32'd1);
      check("ready_after_rst_div3", 32'(req_ready1), 32'd1);

      run_frame("wr_a0ff", 1'b1, 2'b01, 3'b000, 8'hFF, 16'($urandom));
      check("wr_a0ff_literal", 32'(cap_word), 32'h0000A0FF);
      run_frame("rd_5a", 1'b0, 2'b01, 3'b101, 8'hC3, 16'h005A);
      check("rd_5a_literal", 32'(cap_word), 32'h00003400);

      for (int i = 0; i < 6; i++)
         run_frame("rand", 1'($urandom), 2'($urandom), 3'($urandom), 8'($urandom), 16'($urandom));

      // Back-to-back: req_valid stays high across two requests.
      slv_a = 16'($urandom); slv_b = 16'($urandom);
      slv_word = slv_a;
      req_write = 1'b1; req_sel = 2'b10; req_addr = 3'b011; req_wdata = 8'h3C;
      rv = 1'b1;
      wait_ready("b2b_a");
      @(negedge clk);
      req_write = 1'b0; req_sel = 2'b11; req_addr = 3'b110; req_wdata = 8'h99;
      n = 0;
      while (!cur_rsp_valid && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("b2b_a_rsp", 32'(cur_rsp_valid), 32'd1);
      check("b2b_a_mosi", 32'(cap_word), 32'(ref_frame(1'b1, 2'b10, 3'b011, 8'h3C)));
      check("b2b_a_frame", 32'(cur_frame), 32'(slv_a));
      slv_word = slv_b;
      gap = 0; bl = 0; n = 0;
      while (cur_ss && n < 50) begin
         gap++;
         if (!cur_busy) bl++;
         @(negedge clk);
         n++;
      end
      rv = 1'b0;
      check("b2b_gap_ge_idle", 32'(gap >= 2), 32'd1);
      check("b2b_busy_only_idle", 32'(bl <= 1), 32'd1);
      n = 0;
      while (!cur_rsp_valid && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("b2b_b_mosi", 32'(cap_word), 32'(ref_frame(1'b0, 2'b11, 3'b110, 8'h99)));
      check("b2b_b_frame", 32'(cur_frame), 32'(slv_b));
      check("b2b_b_rdata", 32'(cur_rdata), 32'(slv_b[7:0]));
      repeat (4) @(negedge clk);

      dsel = 1'b1;
      @(negedge clk);
      run_frame("div3_wr", 1'b1, 2'b01, 3'b000, 8'hFF, 16'($urandom));
      run_frame("div3_rd", 1'b0, 2'($urandom), 3'($urandom), 8'($urandom), 16'($urandom));
      dsel = 1'b0;
      @(negedge clk);

      // Reset in the middle of a frame.
      slv_c = 16'($urandom);
      slv_word = slv_c;
      req_write = 1'b1; req_sel = 2'b01; req_addr = 3'b010; req_wdata = 8'h55;
      rv = 1'b1;
      wait_ready("mid_rst");
      @(negedge clk);
      rv = 1'b0;
      n = 0;
      while (nrise < 5 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("mid_rst_rises", 32'(nrise), 32'd5);
      resetn = 1'b0;
      #1;
      check("mid_rst_ss", 32'(ss0), 32'd1);
      check("mid_rst_sclk", 32'(sclk0), 32'd0);
      check("mid_rst_rsp_valid", 32'(rsp_valid0), 32'd0);
      check("mid_rst_frame", 32'(rsp_frame0), 32'd0);
      check("mid_rst_rdata", 32'(rsp_rdata0), 32'd0);
      check("mid_rst_busy", 32'(busy0), 32'd0);
      pulses = 0;
      repeat (3) begin
         @(negedge clk);
         if (rsp_valid0) pulses++;
      end
      resetn = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (rsp_valid0) pulses++;
      end
      check("mid_rst_no_rsp", 32'(pulses), 32'd0);
      run_frame("post_rst", 1'b1, 2'b01, 3'b000, 8'hFF, 16'($urandom));
      check("post_rst_literal", 32'(cap_word), 32'h0000A0FF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
